// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared state type and default parameters for histogram_stream
package hist_pkg;

    localparam int HIST_DATA_W        = 15;
    localparam int HIST_BIN_BITS      = 4;
    localparam int HIST_COUNT_W       = 8;
    localparam int HIST_CLEAR_ON_READ = 1;

    // ACC: accumulate samples, READ: stream bins out, CLR: zero one bin per cycle
    typedef enum logic [1:0] {
        ACC  = 2'd0,
        READ = 2'd1,
        CLR  = 2'd2
    } hist_state_e;

endpackage

// File: rtl/histogram_stream_if.sv
// rtl/histogram_stream_if.sv - sample/readout bus of histogram_stream
//
// master: drives samples, commands and out_ready; observes the readout stream.
// slave : the histogram block.
//   data_in/write_en      sample and strobe (bin taken from the top BIN_BITS bits)
//   start_read/clear      command requests, honoured only while ready=1
//   out_ready             downstream accepts the presented beat
//   data_out/bin_idx      count and index of the presented bin (valid_out)
//   last_bin              presented bin is the final one
//   ready                 block is accumulating
//   saturated             sticky: some bin reached its maximum count
import hist_pkg::*;

interface histogram_stream_if #(
    parameter int DATA_W   = HIST_DATA_W,
    parameter int BIN_BITS = HIST_BIN_BITS,
    parameter int COUNT_W  = HIST_COUNT_W
);
    logic [DATA_W-1:0]   data_in;
    logic                write_en;
    logic                start_read;
    logic                clear;
    logic                out_ready;
    logic [COUNT_W-1:0]  data_out;
    logic [BIN_BITS-1:0] bin_idx;
    logic                valid_out;
    logic                last_bin;
    logic                ready;
    logic                saturated;

    modport master (
        output data_in, write_en, start_read, clear, out_ready,
        input  data_out, bin_idx, valid_out, last_bin, ready, saturated
    );

    modport slave (
        input  data_in, write_en, start_read, clear, out_ready,
        output data_out, bin_idx, valid_out, last_bin, ready, saturated
    );
endinterface

// File: rtl/hist_bin_counter.sv
// rtl/hist_bin_counter.sv - one saturating histogram bin counter
//
// clk, rst_n : clock, asynchronous active-low reset
// inc        : add one unless already at maximum
// clr        : zero the count (wins over inc)
// count      : current count
// sat        : count is at its maximum value
import hist_pkg::*;

module hist_bin_counter #(
    parameter int COUNT_W = HIST_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count,
    output logic               sat
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + COUNT_W'(1);
        end
    end

    assign sat = (count == CNT_MAX);

endmodule

// File: rtl/histogram_stream.sv
// rtl/histogram_stream.sv - streaming histogram with handshaked readout and bulk clear
//
// clk, rst_n : clock, asynchronous active-low reset
// bus        : histogram_stream_if slave modport (samples, commands, readout stream)
//
// All outputs are decoded from registers (state, index, bin counters, sticky
// flag), so there is no combinational path from any input to any output.
import hist_pkg::*;

module histogram_stream #(
    parameter int DATA_W        = HIST_DATA_W,
    parameter int BIN_BITS      = HIST_BIN_BITS,
    parameter int COUNT_W       = HIST_COUNT_W,
    parameter int CLEAR_ON_READ = HIST_CLEAR_ON_READ
) (
    input  logic               clk,
    input  logic               rst_n,
    histogram_stream_if.slave  bus
);

    localparam int                  NUM_BINS = 2 ** BIN_BITS;
    localparam logic [BIN_BITS-1:0] LAST_IDX = BIN_BITS'(NUM_BINS - 1);
    localparam logic [COUNT_W-1:0]  NEAR_MAX = '1 - COUNT_W'(1);

    hist_state_e         state;
    logic [BIN_BITS-1:0] idx;
    logic                saturated_q;

    logic [COUNT_W-1:0]  counts [NUM_BINS];
    logic [NUM_BINS-1:0] inc;
    logic [NUM_BINS-1:0] clr;
    logic [NUM_BINS-1:0] sat;

    logic [BIN_BITS-1:0] sel;
    logic                wr_acc;
    logic                rd_hs;
    logic                hit_max;
    logic                unused_sample_bits;

    assign sel    = bus.data_in[DATA_W-1 -: BIN_BITS];
    assign wr_acc = (state == ACC) && bus.write_en;
    assign rd_hs  = (state == READ) && bus.out_ready;

    // The accepted sample leaves its bin at the maximum: either it was one
    // below and is now reaching it, or it was already pinned there.
    assign hit_max = wr_acc && (sat[sel] || (counts[sel] == NEAR_MAX));

    // Bits below the bin field only carry sample resolution we do not bin on.
    assign unused_sample_bits = ^bus.data_in;

    for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
        assign inc[k] = wr_acc && (sel == BIN_BITS'(k));
        // CLR walks idx across every bin; a clear-on-read readout zeroes the
        // bin that is being accepted on this handshake.
        assign clr[k] = (idx == BIN_BITS'(k)) &&
                        ((state == CLR) || ((CLEAR_ON_READ != 0) && rd_hs));

        hist_bin_counter #(
            .COUNT_W (COUNT_W)
        ) u_bin (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[k]),
            .clr   (clr[k]),
            .count (counts[k]),
            .sat   (sat[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACC;
            idx         <= '0;
            saturated_q <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (hit_max) begin
                        saturated_q <= 1'b1;
                    end
                    // clear has priority over start_read
                    if (bus.clear) begin
                        state       <= CLR;
                        idx         <= '0;
                        saturated_q <= 1'b0;
                    end else if (bus.start_read) begin
                        state <= READ;
                        idx   <= '0;
                    end
                end
                READ: begin
                    if (bus.out_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ACC;
                            idx   <= '0;
                            if (CLEAR_ON_READ != 0) begin
                                saturated_q <= 1'b0;
                            end
                        end else begin
                            idx <= idx + BIN_BITS'(1);
                        end
                    end
                end
                CLR: begin
                    if (idx == LAST_IDX) begin
                        state <= ACC;
                        idx   <= '0;
                    end else begin
                        idx <= idx + BIN_BITS'(1);
                    end
                end
                default: begin
                    state <= ACC;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign bus.ready     = (state == ACC);
    assign bus.valid_out = (state == READ);
    assign bus.bin_idx   = (state == READ) ? idx : '0;
    assign bus.last_bin  = (state == READ) && (idx == LAST_IDX);
    assign bus.data_out  = (state == READ) ? counts[idx] : '0;
    assign bus.saturated = saturated_q;

endmodule

// File: tb/tb_histogram_stream.sv
// tb/tb_histogram_stream.sv - randomized self-checking bench for histogram_stream
module tb_histogram_stream;

    localparam int DW   = 15;
    localparam int BB   = 4;
    localparam int CW   = 8;
    localparam int NB   = 16;
    localparam int CMAX = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [DW-1:0] data_in = '0;
    logic write_en = 1'b0;
    logic start_read = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    // Index 0: CLEAR_ON_READ=1, index 1: CLEAR_ON_READ=0. Both see identical inputs.
    histogram_stream_if #(.DATA_W(DW), .BIN_BITS(BB), .COUNT_W(CW)) ifc0 ();
    histogram_stream_if #(.DATA_W(DW), .BIN_BITS(BB), .COUNT_W(CW)) ifc1 ();

    assign ifc0.data_in = data_in;   assign ifc1.data_in = data_in;
    assign ifc0.write_en = write_en; assign ifc1.write_en = write_en;
    assign ifc0.start_read = start_read; assign ifc1.start_read = start_read;
    assign ifc0.clear = clear;       assign ifc1.clear = clear;
    assign ifc0.out_ready = out_ready; assign ifc1.out_ready = out_ready;

    histogram_stream #(.DATA_W(DW), .BIN_BITS(BB), .COUNT_W(CW), .CLEAR_ON_READ(1)) dut_cor (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc0.slave)
    );

    histogram_stream #(.DATA_W(DW), .BIN_BITS(BB), .COUNT_W(CW), .CLEAR_ON_READ(0)) dut_keep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1.slave)
    );

    logic [CW-1:0] dout [2];
    logic [BB-1:0] bidx [2];
    logic vld [2];
    logic lst [2];
    logic rdy [2];
    logic satf [2];

    assign dout[0] = ifc0.data_out;  assign dout[1] = ifc1.data_out;
    assign bidx[0] = ifc0.bin_idx;   assign bidx[1] = ifc1.bin_idx;
    assign vld[0]  = ifc0.valid_out; assign vld[1]  = ifc1.valid_out;
    assign lst[0]  = ifc0.last_bin;  assign lst[1]  = ifc1.last_bin;
    assign rdy[0]  = ifc0.ready;     assign rdy[1]  = ifc1.ready;
    assign satf[0] = ifc0.saturated; assign satf[1] = ifc1.saturated;

    int errors = 0;
    int checks = 0;

    // Reference histogram per instance: plain counts plus a sticky saturation bit.
    int unsigned mcnt [2][NB];
    bit msat [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_zero();
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < NB; b++) mcnt[m][b] = 0;
            msat[m] = 1'b0;
        end
    endfunction

    function automatic void model_write(input int b);
        for (int m = 0; m < 2; m++) begin
            if (mcnt[m][b] < CMAX) mcnt[m][b]++;
            if (mcnt[m][b] == CMAX) msat[m] = 1'b1;
        end
    endfunction

    function automatic logic [DW-1:0] sample_for(input int b);
        logic [DW-1:0] s;
        s = DW'($urandom) & DW'(15'h07FF);
        s[DW-1 -: BB] = BB'(b);
        return s;
    endfunction

    task automatic check_idle(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s ready[%0d]", tag, m), 32'(rdy[m]), 32'd1);
            check($sformatf("%s valid[%0d]", tag, m), 32'(vld[m]), 32'd0);
            check($sformatf("%s last[%0d]", tag, m), 32'(lst[m]), 32'd0);
            check($sformatf("%s sat[%0d]", tag, m), 32'(satf[m]), 32'(msat[m]));
        end
    endtask

    task automatic check_beat(input int b);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("beat%0d valid[%0d]", b, m), 32'(vld[m]), 32'd1);
            check($sformatf("beat%0d ready[%0d]", b, m), 32'(rdy[m]), 32'd0);
            check($sformatf("beat%0d idx[%0d]", b, m), 32'(bidx[m]), 32'(b));
            check($sformatf("beat%0d data[%0d]", b, m), 32'(dout[m]), mcnt[m][b]);
            check($sformatf("beat%0d last[%0d]", b, m), 32'(lst[m]), 32'(b == NB - 1));
            check($sformatf("beat%0d sat[%0d]", b, m), 32'(satf[m]), 32'(msat[m]));
        end
    endtask

    task automatic write_sample(input int b);
        data_in  = sample_for(b);
        write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        model_write(b);
    endtask

    task automatic reset_and_check(input string tag);
        rst_n = 1'b0;
        #1;
        model_zero();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s valid[%0d]", tag, m), 32'(vld[m]), 32'd0);
            check($sformatf("%s last[%0d]", tag, m), 32'(lst[m]), 32'd0);
            check($sformatf("%s data[%0d]", tag, m), 32'(dout[m]), 32'd0);
            check($sformatf("%s idx[%0d]", tag, m), 32'(bidx[m]), 32'd0);
            check($sformatf("%s sat[%0d]", tag, m), 32'(satf[m]), 32'd0);
            check($sformatf("%s ready[%0d]", tag, m), 32'(rdy[m]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full readout starting at a negedge in ACC. wr_bin>=0 writes a sample in
    // the same cycle as start_read. Beat stall_bin is held for stall_len cycles
    // with writes attempted meanwhile; rnd adds random short stalls elsewhere.
    task automatic readout(input int wr_bin, input int stall_bin, input int stall_len, input bit rnd);
        int n;
        start_read = 1'b1;
        if (wr_bin >= 0) begin
            data_in  = sample_for(wr_bin);
            write_en = 1'b1;
        end
        @(negedge clk);
        start_read = 1'b0;
        write_en   = 1'b0;
        if (wr_bin >= 0) model_write(wr_bin);
        for (int b = 0; b < NB; b++) begin
            n = (b == stall_bin) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < n; s++) begin
                out_ready = 1'b0;
                data_in   = sample_for(int'($urandom_range(0, NB - 1)));
                write_en  = 1'b1;
                check_beat(b);
                @(negedge clk);
            end
            write_en  = 1'b0;
            check_beat(b);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            mcnt[0][b] = 0;
            if (b == NB - 1) msat[0] = 1'b0;
        end
        check_idle("after read");
    endtask

    initial begin
        model_zero();
        #2;
        reset_and_check("reset");

        // Bins 3,3,3,15 then a plain readout
        write_sample(3); write_sample(3); write_sample(3); write_sample(15);
        readout(-1, -1, 0, 1'b0);

        // Stall at bin 2 for 5 cycles with writes that must be dropped
        for (int i = 0; i < 20; i++) write_sample(int'($urandom_range(0, NB - 1)));
        write_sample(2);
        readout(-1, 2, 5, 1'b0);

        // Saturation of bin 5
        for (int i = 0; i < 300; i++) write_sample(5);
        check_idle("after 300 writes");
        readout(-1, -1, 0, 1'b1);
        readout(-1, -1, 0, 1'b0);

        // clear together with start_read: clear wins, 16 busy cycles
        for (int i = 0; i < 10; i++) write_sample(int'($urandom_range(0, NB - 1)));
        clear      = 1'b1;
        start_read = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        start_read = 1'b0;
        model_zero();
        for (int c = 0; c < NB; c++) begin
            data_in  = sample_for(int'($urandom_range(0, NB - 1)));
            write_en = 1'b1;
            for (int m = 0; m < 2; m++) begin
                check($sformatf("clr%0d ready[%0d]", c, m), 32'(rdy[m]), 32'd0);
                check($sformatf("clr%0d valid[%0d]", c, m), 32'(vld[m]), 32'd0);
                check($sformatf("clr%0d sat[%0d]", c, m), 32'(satf[m]), 32'd0);
            end
            @(negedge clk);
        end
        write_en = 1'b0;
        check_idle("after clear");
        readout(-1, -1, 0, 1'b0);

        // Sample written with start_read appears; consecutive readouts
        for (int i = 0; i < 12; i++) write_sample(int'($urandom_range(0, NB - 1)));
        readout(9, -1, 0, 1'b1);
        readout(0, -1, 0, 1'b1);
        readout(-1, -1, 0, 1'b0);

        // Reset in the middle of a readout at bin 7
        for (int i = 0; i < 8; i++) write_sample(int'($urandom_range(0, NB - 1)));
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        out_ready  = 1'b1;
        repeat (7) @(negedge clk);
        out_ready  = 1'b0;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("pre-abort idx[%0d]", m), 32'(bidx[m]), 32'd7);
            check($sformatf("pre-abort valid[%0d]", m), 32'(vld[m]), 32'd1);
        end
        reset_and_check("abort reset");
        readout(-1, -1, 0, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 6; it++) begin
            int nw;
            nw = int'($urandom_range(0, 30));
            for (int i = 0; i < nw; i++) write_sample(int'($urandom_range(0, NB - 1)));
            readout(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB - 1)) : -1,
                    int'($urandom_range(0, NB - 1)), int'($urandom_range(1, 4)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/histogram_stream.md
HISTOGRAM_STREAM -- requirements
Module: histogram_stream

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 15, meaning sample width.
REQ-002 The block SHALL have parameter BIN_BITS, default 4, meaning log2 of bin count (NUM_BINS = 2**BIN_BITS).
REQ-003 The block SHALL have parameter COUNT_W, default 8, meaning per-bin counter width.
REQ-004 The block SHALL have parameter CLEAR_ON_READ, default 1, meaning 1 zeroes each bin as it is read out and 0 keeps counts.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port data_in, input, DATA_W bits: sample; bin = data_in[DATA_W-1 -: BIN_BITS].
REQ-008 The block SHALL have port write_en, input, 1 bit: sample strobe, accepted only when ready=1.
REQ-009 The block SHALL have port start_read, input, 1 bit: request readout stream.
REQ-010 The block SHALL have port clear, input, 1 bit: request zeroing of all bins.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts data_out.
REQ-012 The block SHALL have port data_out, output, COUNT_W bits: count of the bin currently presented.
REQ-013 The block SHALL have port bin_idx, output, BIN_BITS bits: index of the bin currently presented.
REQ-014 The block SHALL have port valid_out, output, 1 bit: data_out/bin_idx valid.
REQ-015 The block SHALL have port last_bin, output, 1 bit: high with valid_out on bin NUM_BINS-1.
REQ-016 The block SHALL have port ready, output, 1 bit: block is in ACC and accepts samples.
REQ-017 The block SHALL have port saturated, output, 1 bit: sticky flag, some bin hit its maximum.

Function
REQ-018 States SHALL be ACC, READ and CLR; ready SHALL be 1 only in ACC.
REQ-019 In ACC, write_en=1 SHALL increment the selected bin by 1 at the next edge, a 1-cycle update latency.
REQ-020 A bin at 2**COUNT_W-1 SHALL hold its value on increment, and saturated SHALL set and stay set until the next clear or a CLEAR_ON_READ readout.
REQ-021 In ACC, clear=1 SHALL move the block to CLR, which zeroes bin k on the k-th cycle (NUM_BINS cycles) and returns to ACC after bin NUM_BINS-1; saturated SHALL drop on entry to CLR.
REQ-022 In ACC, start_read=1 with clear=0 SHALL move the block to READ with index 0; valid_out SHALL be 1 throughout READ.
REQ-023 In READ, the index SHALL advance only on valid_out and out_ready; data_out and bin_idx SHALL hold while out_ready=0.
REQ-024 With CLEAR_ON_READ=1, a bin SHALL be zeroed on its accepting handshake.
REQ-025 The handshake with last_bin=1 SHALL return the block to ACC at the next edge; with CLEAR_ON_READ=1, saturated SHALL clear at that point.
REQ-026 If write_en and start_read are both 1 in ACC, the sample SHALL be counted and the readout SHALL include it.
REQ-027 If clear and start_read are both 1 in ACC, clear SHALL win and start_read SHALL be ignored.
REQ-028 write_en while ready=0 SHALL be dropped with no state change; start_read or clear outside ACC SHALL be ignored.
REQ-029 Outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-030 rst_n=0 SHALL asynchronously set state ACC, all bins 0, index 0, valid_out=0, last_bin=0, data_out=0, bin_idx=0, saturated=0 and ready=1.
REQ-031 Reset mid-READ or mid-CLR SHALL abort the operation immediately, with no partial stream resumed.

Structure
REQ-032 Package hist_pkg SHALL hold the state enum type (ACC, READ, CLR) and the default parameter constants.
REQ-033 One sub-module, hist_bin_counter (COUNT_W saturating counter with inc, clr and sat outputs), SHALL be instantiated NUM_BINS times.
REQ-034 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-035 Reset, then samples with bins 3,3,3,15, then start_read with out_ready=1 -> 16 beats; bin3=3, bin15=4'd1 with last_bin=1; all others 0; ready returns the cycle after the last beat.
REQ-036 COUNT_W=8, write 300 samples to bin 5 -> bin5 reads 255 and saturated=1; after the CLEAR_ON_READ readout, saturated=0 and a second readout is all zeros.
REQ-037 Hold out_ready=0 for 5 cycles at bin 2 -> data_out and bin_idx stable, valid_out=1, no advance; write_en during READ is dropped (count unchanged).
REQ-038 Counts loaded, clear=1 and start_read=1 in the same cycle -> ready=0 for exactly 16 cycles, no valid_out, and a subsequent readout is all zeros.
REQ-039 Assert rst_n=0 during READ at bin 7 -> valid_out=0 immediately, ready=1, and a readout is all zeros.
REQ-040 CLEAR_ON_READ=0 with two consecutive readouts -> identical counts; write_en with start_read in the same cycle -> that sample appears in the stream.
